// File: rtl/edge_delay_meter.sv
// rtl/edge_delay_meter.sv - start-to-stop edge delay meter reporting units/fraction over valid/ready
// Optional feature macro: EDM_AUTO_REARM_EN (re-arm automatically after each accepted result).
module edge_delay_meter #(
    parameter int PREC_DIV      = 10,
    parameter int CNT_W         = 16,
    parameter int TIMEOUT_UNITS = 1000,
    localparam int FRAC_W       = $clog2(PREC_DIV)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              start_in,
    input  logic              stop_in,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_units,
    output logic [FRAC_W-1:0] res_frac,
    output logic              res_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_MEASURE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                start_prev_q, stop_prev_q;
    logic [FRAC_W-1:0]   frac_q, frac_d, frac_inc;
    logic [CNT_W-1:0]    unit_q, unit_d, unit_inc;
    logic [CNT_W-1:0]    res_units_q, res_units_d;
    logic [FRAC_W-1:0]   res_frac_q, res_frac_d;
    logic                res_timeout_q, res_timeout_d;
    logic                start_rise, stop_rise, hit_limit;

    assign start_rise = start_in & ~start_prev_q;
    assign stop_rise  = stop_in & ~stop_prev_q;

    // Elapsed count including the current edge, so a stop on this edge latches T directly.
    always_comb begin
        frac_inc = frac_q + 1'b1;
        unit_inc = unit_q;
        if (frac_q == FRAC_W'(PREC_DIV - 1)) begin
            frac_inc = '0;
            unit_inc = unit_q + 1'b1;
        end
    end

    assign hit_limit = (unit_inc == CNT_W'(TIMEOUT_UNITS)) && (frac_inc == '0);

    always_comb begin
        state_d       = state_q;
        frac_d        = frac_q;
        unit_d        = unit_q;
        res_units_d   = res_units_q;
        res_frac_d    = res_frac_q;
        res_timeout_d = res_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (arm) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (start_rise) begin
                    state_d = S_MEASURE;
                    frac_d  = '0;
                    unit_d  = '0;
                end
            end
            S_MEASURE: begin
                frac_d = frac_inc;
                unit_d = unit_inc;
                if (stop_rise || hit_limit) begin
                    state_d       = S_DONE;
                    res_units_d   = unit_inc;
                    res_frac_d    = frac_inc;
                    res_timeout_d = ~stop_rise;
                end
            end
            S_DONE: begin
                if (res_ready) begin
`ifdef EDM_AUTO_REARM_EN
                    state_d = S_ARMED;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            start_prev_q  <= 1'b0;
            stop_prev_q   <= 1'b0;
            frac_q        <= '0;
            unit_q        <= '0;
            res_units_q   <= '0;
            res_frac_q    <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_prev_q  <= start_in;
            stop_prev_q   <= stop_in;
            frac_q        <= frac_d;
            unit_q        <= unit_d;
            res_units_q   <= res_units_d;
            res_frac_q    <= res_frac_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign busy        = (state_q == S_ARMED) || (state_q == S_MEASURE);
    assign res_valid   = (state_q == S_DONE);
    assign res_units   = res_units_q;
    assign res_frac    = res_frac_q;
    assign res_timeout = res_timeout_q;

endmodule

// File: doc/edge_delay_meter.md
# edge_delay_meter

Measures the delay between a rising edge on `start_in` and the next rising edge on `stop_in`, in clock ticks. The result is reported as whole units plus a sub-unit fraction, where one unit is `PREC_DIV` ticks. A 1 ms / 100 us timescale therefore maps to `PREC_DIV=10`. The block sits in the bench/verification infrastructure as the measuring counterpart of delayed-event generators: something else schedules an event after a fractional delay, and this block times it and hands the result off over a valid/ready port.

## Interface
Parameters:
- `PREC_DIV`, default 10: ticks per unit; must be ≥2. Localparam `FRAC_W = $clog2(PREC_DIV)`.
- `CNT_W`, default 16: width of the units field.
- `TIMEOUT_UNITS`, default 1000: units limit; must be less than 2^CNT_W.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all logic samples on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `arm`  in  1  single-cycle request to begin a measurement.
- `start_in`  in  1  start event, level input, already synchronous to `clk`.
- `stop_in`  in  1  stop event, level input, already synchronous to `clk`.
- `busy`  out  1  high in ARMED or MEASURE.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_units`  out  CNT_W  whole units of the measured delay.
- `res_frac`  out  FRAC_W  remaining ticks, range 0..PREC_DIV-1.
- `res_timeout`  out  1  measurement ended by timeout, not by a stop edge.

## Operation
- Edge detect:
  - `start_prev` and `stop_prev` register their inputs every cycle, in every state; both reset to 0.
  - rise = input & ~prev.
- FSM states: IDLE, ARMED, MEASURE, DONE.
- IDLE:
  - `arm` → ARMED.
  - Start/stop edges are ignored.
- ARMED:
  - A start rise → MEASURE, with counters cleared (`frac_cnt=0`, `unit_cnt=0`).
  - Stop rises are ignored.
  - A start rise on the same edge that `arm` was sampled is not seen, because the FSM is still in IDLE on that edge.
- MEASURE:
  - Fraction counter counts 0..PREC_DIV-1; on wrap it returns to 0 and `unit_cnt` increments.
  - The latched result equals T = number of clock edges from the edge that detected the start rise to the edge that detected the stop rise: `res_units = T / PREC_DIV`, `res_frac = T % PREC_DIV`.
  - A stop rise → DONE with T latched and `res_timeout=0`.
  - A stop rise on the same edge as the start detection is ignored, since the FSM was in ARMED.
  - Further start rises are ignored.
- Timeout: when T reaches `TIMEOUT_UNITS*PREC_DIV` with no stop rise → DONE with `res_units=TIMEOUT_UNITS`, `res_frac=0`, `res_timeout=1`. A stop rise on that exact edge wins: `res_timeout=0`, same value.
- DONE:
  - `res_valid=1`; result fields hold stable until accepted.
  - Transfer occurs on `res_valid & res_ready`; next state IDLE.
- `arm` is ignored outside IDLE.
- `busy` = state ∈ {ARMED, MEASURE}.

## Timing
- All outputs reset (rst_n=0, asynchronous) to 0; FSM → IDLE; counters and prev registers → 0.
- `arm` sampled at edge A → `busy` high after edge A. The earliest start rise accepted is the one detected at edge A+1.
- Stop rise detected at edge M → `res_valid` high after edge M, i.e. zero added latency.
- `res_ready` may be held high in advance. The handshake completes on the first edge with `res_valid` high, and `res_valid` drops after that edge.
- Minimum measurable T = 1 (stop rise detected on the edge after start detection).
- Back-to-back measurement: after acceptance at edge D, IDLE is entered; `arm` at D+1 is the earliest arm.
- Reset asserted mid-MEASURE or mid-DONE: result discarded, `res_valid` drops immediately (asynchronously), no partial result is reported.

## Configuration
- `EDM_AUTO_REARM_EN`:
  - Defined: on result acceptance the FSM goes directly to ARMED instead of IDLE. `busy` rises on the acceptance edge, and `arm` is needed only for the first measurement after reset.
  - Undefined: return to IDLE as specified above, and every measurement requires `arm`.

## Test plan
- PREC_DIV=10, `arm` at edge 0, start rise at edge 5, stop rise at edge 29 → `res_units=2`, `res_frac=4`, `res_timeout=0`. Repeat with stop at edge 31 → 2/6; the two results must differ.
- TIMEOUT_UNITS=3, start rise, no stop → `res_valid` 30 edges after start detection, with 3/0/`res_timeout=1`.
- `res_ready` held low for 20 cycles after `res_valid` → fields and `res_valid` stable throughout; one transfer on `res_ready`, then IDLE with `busy=0`.
- `start_in` rises on the same edge `arm` is sampled, stays high, and a second rise follows 4 cycles later → measurement starts on the second rise only. Stop rise on the start-detection edge → ignored.
- `rst_n` pulsed low mid-MEASURE (T=7) → `busy` and `res_valid` go 0 immediately, with no result. A fresh arm/start/stop with T=13 → 1/3.
- With `EDM_AUTO_REARM_EN` defined: two start/stop pairs (T=12, then T=8) with a single `arm` → two results, 1/2 then 0/8. Without the macro, the second pair produces no result.
